// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
//
// APB slave in front of a small byte-wide register-file memory. The master's
// setup phase is captured (address, direction, write data) and compared
// against the bus during the access phase. Any change, or an address beyond
// the implemented depth, completes with PSLVERR and suppresses the write.
// Reads are served from the setup edge, so PRDATA is already stable when
// PREADY rises.
//
// Optional feature (macro APB_SLAVE_WAIT_EN):
//   defined   - every access phase holds PREADY low for WAIT_CYCLES cycles.
//   undefined - zero-wait slave. No wait counter exists and WAIT_CYCLES is
//               ignored.
//
// Parameters:
//   DEPTH        number of 8-bit words (power of 2, at most 256)
//   WAIT_CYCLES  wait states per access when APB_SLAVE_WAIT_EN is defined (0-15)
//
// Ports:
//   PCLK      in   clock, rising edge
//   PRESETn   in   asynchronous active-low reset (also clears the memory)
//   PSEL      in   slave select
//   PENABLE   in   access-phase indicator
//   PWRITE    in   1 = write, 0 = read
//   PADDR     in   [7:0] word address
//   PWDATA    in   [7:0] write data
//   PRDATA    out  [7:0] registered read data
//   PREADY    out  transfer complete, decoded from registered state
//   PSLVERR   out  error response, only ever high together with PREADY
// -----------------------------------------------------------------------------
module apb_slave_mem #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACCESS = 1'b1;

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The depth is held in 9 bits so that DEPTH = 256 still compares correctly.
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  // True when the address selects an implemented word.
  function automatic logic addr_in_range(input logic [7:0] addr);
    return ({1'b0, addr} < DEPTH_W);
  endfunction

  logic           state_r;
  logic [7:0]     addr_r;
  logic [7:0]     wdata_r;
  logic           write_r;
  logic [7:0]     prdata_r;
  logic [7:0]     mem_r [DEPTH];

  logic           setup_s;
  logic           access_s;
  logic           pready_s;
  logic           mismatch_s;
  logic           pslverr_s;
  logic           complete_s;
  logic           mem_we_s;

  assign setup_s  = PSEL & ~PENABLE;
  assign access_s = (state_r == ST_ACCESS);

`ifdef APB_SLAVE_WAIT_EN
  logic [3:0] wcnt_r;

  // Ready once the wait counter loaded at setup has run down.
  always_comb begin
    pready_s = 1'b0;
    if (access_s && (wcnt_r == 4'd0)) begin
      pready_s = 1'b1;
    end else begin
      pready_s = 1'b0;
    end
  end

  // Wait counter: loaded at setup, counts down only while the master sits in
  // a valid access phase.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wcnt_r <= 4'd0;
    end else if (!access_s && setup_s) begin
      wcnt_r <= 4'(WAIT_CYCLES);
    end else if (access_s && PSEL && PENABLE && (wcnt_r != 4'd0)) begin
      wcnt_r <= wcnt_r - 4'd1;
    end else if (access_s && !PSEL) begin
      wcnt_r <= 4'd0;
    end
  end
`else
  // Zero-wait build: the first access cycle is always the completing one.
  always_comb begin
    pready_s = 1'b0;
    if (access_s) begin
      pready_s = 1'b1;
    end else begin
      pready_s = 1'b0;
    end
  end

  // WAIT_CYCLES has no effect in the zero-wait build.
  logic [3:0] unused_wait_cycles_s;
  assign unused_wait_cycles_s = 4'(WAIT_CYCLES);
`endif

  // The bus must still present the transfer that was captured at setup.
  // Write data is irrelevant to a read.
  always_comb begin
    mismatch_s = 1'b0;
    if ((PADDR != addr_r) || (PWRITE != write_r)) begin
      mismatch_s = 1'b1;
    end else if (write_r && (PWDATA != wdata_r)) begin
      mismatch_s = 1'b1;
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Error response, gated by ready so it can never appear without it.
  always_comb begin
    pslverr_s = 1'b0;
    if (pready_s) begin
      pslverr_s = mismatch_s | ~addr_in_range(addr_r);
    end else begin
      pslverr_s = 1'b0;
    end
  end

  assign complete_s = access_s & PSEL & PENABLE & pready_s;
  assign mem_we_s   = complete_s & write_r & ~pslverr_s;

  // Transfer FSM with setup capture and read-data load.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r  <= ST_IDLE;
      addr_r   <= 8'h00;
      wdata_r  <= 8'h00;
      write_r  <= 1'b0;
      prdata_r <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // PSEL with PENABLE but no setup seen is not a transfer: ignore it.
          if (setup_s) begin
            state_r <= ST_ACCESS;
            addr_r  <= PADDR;
            wdata_r <= PWDATA;
            write_r <= PWRITE;
            if (!PWRITE) begin
              prdata_r <= addr_in_range(PADDR) ? mem_r[PADDR[AW-1:0]] : 8'h00;
            end
          end
        end
        ST_ACCESS: begin
          // Losing PSEL aborts the transfer. Completion frees the slave for
          // a back-to-back setup in the very next cycle.
          if (!PSEL || complete_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory array: cleared by reset and written only by an error-free completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (mem_we_s) begin
      mem_r[addr_r[AW-1:0]] <= wdata_r;
    end
  end

  assign PRDATA  = prdata_r;
  assign PREADY  = pready_s;
  assign PSLVERR = pslverr_s;

endmodule
